csr_excp_ctrl: RTL and testbench

//  Commit-point exception/interrupt scheduler for the CSR unit. Sits between the WB stage and the CSR file:

---
 rtl/csr_excp_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_csr_excp_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/csr_excp_ctrl.sv
// Commit-point exception/interrupt scheduler between the WB stage and the CSR file.
// Arbitrates interrupt, synchronous exception, ertn, refetch and idle events of the
// retiring instruction, issues one registered single-cycle event pulse to the CSR
// file, and sequences the pipeline flush and the idle-wait.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   wb_valid / wb_ready        retire slot handshake (ready only while running)
//   wb_pc, wb_exc, wb_excode,
//   wb_esubcode, wb_badv       retiring instruction and its exception payload
//   wb_ertn, wb_refetch,
//   wb_idle                    special-instruction flags
//   ie, lie, is                CRMD.IE, ECFG local enables, ESTAT pending bits
//   is_exc, is_ertn,
//   is_fetch_again, is_idle    mutually exclusive single-cycle event pulses
//   excode, esubcode,
//   badvaddr, csr_pc           event payload, held between events
//   commit                     instruction architecturally retired
//   flush_o                    flush stages younger than WB
//   fetch_stall                hold IF while waiting in idle
module csr_excp_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned INT_NUM      = 12,
    parameter logic [5:0]  EXCODE_INT   = 6'h00
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wb_valid,
    output logic               wb_ready,
    input  logic [31:0]        wb_pc,
    input  logic               wb_exc,
    input  logic [5:0]         wb_excode,
    input  logic [8:0]         wb_esubcode,
    input  logic [31:0]        wb_badv,
    input  logic               wb_ertn,
    input  logic               wb_refetch,
    input  logic               wb_idle,
    input  logic               ie,
    input  logic [INT_NUM-1:0] lie,
    input  logic [INT_NUM-1:0] is,
    output logic               is_exc,
    output logic [5:0]         excode,
    output logic [8:0]         esubcode,
    output logic [31:0]        badvaddr,
    output logic [31:0]        csr_pc,
    output logic               is_ertn,
    output logic               is_fetch_again,
    output logic               is_idle,
    output logic               commit,
    output logic               flush_o,
    output logic               fetch_stall
);

    localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_IDLE  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_exc_q, is_exc_d;
    logic              is_ertn_q, is_ertn_d;
    logic              is_fetch_again_q, is_fetch_again_d;
    logic              is_idle_q, is_idle_d;
    logic              commit_q, commit_d;
    logic              flush_q, flush_d;
    logic              fetch_stall_q, fetch_stall_d;
    logic [5:0]        excode_q, excode_d;
    logic [8:0]        esubcode_q, esubcode_d;
    logic [31:0]       badvaddr_q, badvaddr_d;
    logic [31:0]       csr_pc_q, csr_pc_d;

    logic wake;
    logic int_pend;

    // wake ignores IE so idle is left even with interrupts globally masked
    assign wake     = |(lie & is);
    assign int_pend = ie & wake;
    assign wb_ready = (state_q == S_RUN);

    // Next-state and event arbitration
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        is_exc_d         = 1'b0;
        is_ertn_d        = 1'b0;
        is_fetch_again_d = 1'b0;
        is_idle_d        = 1'b0;
        commit_d         = 1'b0;
        excode_d         = excode_q;
        esubcode_d       = esubcode_q;
        badvaddr_d       = badvaddr_q;
        csr_pc_d         = csr_pc_q;

        case (state_q)
            S_RUN: begin
                if (wb_valid) begin
                    if (int_pend) begin
                        is_exc_d   = 1'b1;
                        excode_d   = EXCODE_INT;
                        esubcode_d = 9'd0;
                        csr_pc_d   = wb_pc;
                        state_d    = S_FLUSH;
                        cnt_d      = CNT_LOAD;
                    end else if (wb_exc) begin
                        is_exc_d   = 1'b1;
                        excode_d   = wb_excode;
                        esubcode_d = wb_esubcode;
                        badvaddr_d = wb_badv;
                        csr_pc_d   = wb_pc;
                        state_d    = S_FLUSH;
                        cnt_d      = CNT_LOAD;
                    end else if (wb_ertn) begin
                        is_ertn_d  = 1'b1;
                        commit_d   = 1'b1;
                        state_d    = S_FLUSH;
                        cnt_d      = CNT_LOAD;
                    end else if (wb_refetch) begin
                        is_fetch_again_d = 1'b1;
                        csr_pc_d         = wb_pc;
                        commit_d         = 1'b1;
                        state_d          = S_FLUSH;
                        cnt_d            = CNT_LOAD;
                    end else if (wb_idle) begin
                        is_idle_d = 1'b1;
                        csr_pc_d  = wb_pc;
                        commit_d  = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        commit_d  = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_IDLE: begin
                // csr_pc still holds the idle pc; nothing else writes it while idling
                if (wake) begin
                    is_exc_d   = 1'b1;
                    excode_d   = EXCODE_INT;
                    esubcode_d = 9'd0;
                    csr_pc_d   = csr_pc_q + 32'd4;
                    state_d    = S_FLUSH;
                    cnt_d      = CNT_LOAD;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase

        // idle flushes younger stages only in its pulse cycle
        flush_d       = (state_d == S_FLUSH) | is_idle_d;
        fetch_stall_d = (state_d == S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_RUN;
            cnt_q            <= '0;
            is_exc_q         <= 1'b0;
            is_ertn_q        <= 1'b0;
            is_fetch_again_q <= 1'b0;
            is_idle_q        <= 1'b0;
            commit_q         <= 1'b0;
            flush_q          <= 1'b0;
            fetch_stall_q    <= 1'b0;
            excode_q         <= 6'd0;
            esubcode_q       <= 9'd0;
            badvaddr_q       <= 32'd0;
            csr_pc_q         <= 32'd0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            is_exc_q         <= is_exc_d;
            is_ertn_q        <= is_ertn_d;
            is_fetch_again_q <= is_fetch_again_d;
            is_idle_q        <= is_idle_d;
            commit_q         <= commit_d;
            flush_q          <= flush_d;
            fetch_stall_q    <= fetch_stall_d;
            excode_q         <= excode_d;
            esubcode_q       <= esubcode_d;
            badvaddr_q       <= badvaddr_d;
            csr_pc_q         <= csr_pc_d;
        end
    end

    assign is_exc         = is_exc_q;
    assign is_ertn        = is_ertn_q;
    assign is_fetch_again = is_fetch_again_q;
    assign is_idle        = is_idle_q;
    assign commit         = commit_q;
    assign flush_o        = flush_q;
    assign fetch_stall    = fetch_stall_q;
    assign excode         = excode_q;
    assign esubcode       = esubcode_q;
    assign badvaddr       = badvaddr_q;
    assign csr_pc         = csr_pc_q;

endmodule

// File: tb/tb_csr_excp_ctrl.sv
// Self-checking bench for csr_excp_ctrl: directed scenarios followed by random
// retire traffic, all checked against a cycle-level behavioural model.
module tb_csr_excp_ctrl;

    localparam int unsigned FC     = 2;
    localparam int unsigned NI     = 12;
    localparam logic [5:0]  EXCINT = 6'h00;

    logic          clk = 1'b0;
    logic          reset;
    logic          wb_valid;
    logic          wb_ready;
    logic [31:0]   wb_pc;
    logic          wb_exc;
    logic [5:0]    wb_excode;
    logic [8:0]    wb_esubcode;
    logic [31:0]   wb_badv;
    logic          wb_ertn;
    logic          wb_refetch;
    logic          wb_idle;
    logic          ie;
    logic [NI-1:0] lie;
    logic [NI-1:0] is;
    logic          is_exc;
    logic [5:0]    excode;
    logic [8:0]    esubcode;
    logic [31:0]   badvaddr;
    logic [31:0]   csr_pc;
    logic          is_ertn;
    logic          is_fetch_again;
    logic          is_idle;
    logic          commit;
    logic          flush_o;
    logic          fetch_stall;

    always #5 clk = ~clk;

    csr_excp_ctrl #(.FLUSH_CYCLES(FC), .INT_NUM(NI), .EXCODE_INT(EXCINT)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pc(wb_pc),
        .wb_exc(wb_exc), .wb_excode(wb_excode), .wb_esubcode(wb_esubcode), .wb_badv(wb_badv),
        .wb_ertn(wb_ertn), .wb_refetch(wb_refetch), .wb_idle(wb_idle),
        .ie(ie), .lie(lie), .is(is),
        .is_exc(is_exc), .excode(excode), .esubcode(esubcode), .badvaddr(badvaddr),
        .csr_pc(csr_pc), .is_ertn(is_ertn), .is_fetch_again(is_fetch_again),
        .is_idle(is_idle), .commit(commit), .flush_o(flush_o), .fetch_stall(fetch_stall)
    );

    int checks   = 0;
    int failures = 0;

    // Model state: flush cycles still owed (including the current one) and idle status
    int          m_busy;
    bit          m_idling;
    logic [31:0] m_idle_pc;

    // Expected post-edge outputs
    logic        e_exc, e_ertn, e_fa, e_idle, e_commit, e_flush, e_stall, e_ready;
    logic [5:0]  e_excode;
    logic [8:0]  e_esub;
    logic [31:0] e_badv, e_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        wb_valid = 0; wb_pc = 32'h0; wb_exc = 0; wb_excode = 6'h0; wb_esubcode = 9'h0;
        wb_badv = 32'h0; wb_ertn = 0; wb_refetch = 0; wb_idle = 0;
        ie = 0; lie = '0; is = '0; reset = 0;
    endtask

    // Predict outputs after the coming edge from the rules for the current inputs
    task automatic model_step();
        bit wk, ip, event_fl;
        wk = |(lie & is);
        ip = ie && wk;
        e_exc = 0; e_ertn = 0; e_fa = 0; e_idle = 0; e_commit = 0;
        event_fl = 0;
        if (reset) begin
            m_busy = 0; m_idling = 0; m_idle_pc = 0;
            e_excode = 0; e_esub = 0; e_badv = 0; e_pc = 0;
        end else if (m_busy > 0) begin
            m_busy--;
        end else if (m_idling) begin
            if (wk) begin
                e_exc = 1; e_excode = EXCINT; e_esub = 0;
                e_pc = m_idle_pc + 32'd4;
                m_idling = 0; event_fl = 1;
            end
        end else if (wb_valid) begin
            if (ip) begin
                e_exc = 1; e_excode = EXCINT; e_esub = 0; e_pc = wb_pc; event_fl = 1;
            end else if (wb_exc) begin
                e_exc = 1; e_excode = wb_excode; e_esub = wb_esubcode; e_badv = wb_badv;
                e_pc = wb_pc; event_fl = 1;
            end else if (wb_ertn) begin
                e_ertn = 1; e_commit = 1; event_fl = 1;
            end else if (wb_refetch) begin
                e_fa = 1; e_pc = wb_pc; e_commit = 1; event_fl = 1;
            end else if (wb_idle) begin
                e_idle = 1; e_pc = wb_pc; e_commit = 1; m_idling = 1; m_idle_pc = wb_pc;
            end else begin
                e_commit = 1;
            end
        end
        if (event_fl) m_busy = FC;
        e_flush = (m_busy > 0) || e_idle;
        e_stall = m_idling;
        e_ready = (m_busy == 0) && !m_idling;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check("is_exc",         32'(is_exc),         32'(e_exc));
        check("is_ertn",        32'(is_ertn),        32'(e_ertn));
        check("is_fetch_again", 32'(is_fetch_again), 32'(e_fa));
        check("is_idle",        32'(is_idle),        32'(e_idle));
        check("commit",         32'(commit),         32'(e_commit));
        check("flush_o",        32'(flush_o),        32'(e_flush));
        check("fetch_stall",    32'(fetch_stall),    32'(e_stall));
        check("wb_ready",       32'(wb_ready),       32'(e_ready));
        check("excode",         32'(excode),         32'(e_excode));
        check("esubcode",       32'(esubcode),       32'(e_esub));
        check("badvaddr",       badvaddr,            e_badv);
        check("csr_pc",         csr_pc,              e_pc);
    endtask

    initial begin
        m_busy = 0; m_idling = 0; m_idle_pc = 0;
        clear_in();

        // Reset
        reset = 1; step(); reset = 0;
        check("rst_ready", 32'(wb_ready), 32'd1);

        // Plain retire
        wb_valid = 1; wb_pc = 32'h1c000000; step();
        check("plain_commit", 32'(commit), 32'd1);
        check("plain_flush", 32'(flush_o), 32'd0);
        clear_in(); step();

        // Synchronous exception
        wb_valid = 1; wb_pc = 32'h1c000004; wb_exc = 1; wb_excode = 6'h09;
        wb_esubcode = 9'h3; wb_badv = 32'h1234; step();
        check("exc_excode", 32'(excode), 32'h09);
        check("exc_badv", badvaddr, 32'h1234);
        clear_in(); wb_valid = 1; wb_pc = 32'h1c000008;
        repeat (4) step();
        clear_in();

        // Interrupt beats ertn in the same slot
        wb_valid = 1; wb_pc = 32'h1c000010; wb_ertn = 1; ie = 1;
        lie[11] = 1; is[11] = 1; step();
        check("int_no_ertn", 32'(is_ertn), 32'd0);
        check("int_exc", 32'(is_exc), 32'd1);
        clear_in(); repeat (3) step();

        // Idle then wake
        wb_valid = 1; wb_pc = 32'h1c000100; wb_idle = 1; step();
        clear_in(); wb_valid = 1; wb_pc = 32'h1c000104;
        repeat (10) step();
        check("idle_stall", 32'(fetch_stall), 32'd1);
        lie[2] = 1; is[2] = 1; step();
        check("wake_pc", csr_pc, 32'h1c000104);
        clear_in(); repeat (3) step();

        // Idle pc+4 wraps
        wb_valid = 1; wb_pc = 32'hfffffffc; wb_idle = 1; step();
        clear_in(); repeat (2) step();
        lie[0] = 1; is[0] = 1; step();
        check("wrap_pc", csr_pc, 32'h0);
        clear_in(); repeat (3) step();

        // Reset while flushing
        wb_valid = 1; wb_pc = 32'h1c000200; wb_refetch = 1; step();
        clear_in(); reset = 1; step(); reset = 0;
        check("rst_flush_ready", 32'(wb_ready), 32'd1);

        // Reset while idling
        wb_valid = 1; wb_pc = 32'h1c000300; wb_idle = 1; step();
        clear_in(); step();
        reset = 1; step(); reset = 0;
        check("rst_idle_stall", 32'(fetch_stall), 32'd0);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            reset       = ($urandom_range(0, 99) == 0);
            wb_valid    = ($urandom_range(0, 3) != 0);
            wb_pc       = {$urandom} & 32'hfffffffc;
            wb_exc      = ($urandom_range(0, 7) == 0);
            wb_excode   = 6'($urandom);
            wb_esubcode = 9'($urandom);
            wb_badv     = $urandom;
            wb_ertn     = ($urandom_range(0, 7) == 0);
            wb_refetch  = ($urandom_range(0, 7) == 0);
            wb_idle     = ($urandom_range(0, 5) == 0);
            ie          = ($urandom_range(0, 1) == 1);
            lie         = NI'($urandom);
            is          = ($urandom_range(0, 7) == 0) ? NI'($urandom) : '0;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
